life_monitor: RTL
=================

Name: life_monitor

Overview:
Downstream observer for the 8x8 Game-of-Life grid. It samples the grid's `cells` bus every clock, where one clock equals one generation, and counts generations and live population. It classifies the run as extinct, still-life, period-2 oscillator or timeout, then freezes a result snapshot for display or readout logic.

Parameters:
- MAX_GENS, 1000: generation budget; reaching it without another classification yields TIMEOUT. Legal range 3..65535.
- GEN_W, 16: width of the generation counter. Must satisfy 2^GEN_W > MAX_GENS.

Ports:
- clk  in  1  system clock; one rising edge = one generation.
- rst  in  1  synchronous, active-high reset; shared with the grid.
- cells  in  [7:0][7:0]  current grid state. Cell (r,c) is cells[r][c], flat bit r*8+c, matching the seed numbering.
- gen_count  out  GEN_W  number of generations sampled since reset.
- population  out  7  live-cell count of the last sampled generation (0..64).
- status  out  3  life_pkg::status_e classification.
- done  out  1  sticky; high once status is no longer ST_RUN.
- done_pulse  out  1  one-cycle strobe in the first cycle that done is high.
- final_cells  out  64  grid snapshot captured at the classifying edge.

Behaviour:
- Reset: every output is 0, and status = ST_RUN (encoded 0). prev1, prev2 and the valid flags are cleared. Samples taken while rst=1 are ignored.
- Edge numbering: edge k is the k-th rising edge with rst=0 after reset. It samples generation k-1 (gen 0 = seeds).
- At each edge while done=0, with G = cells and P = popcount(G):
  - gen_count <= k.
  - population <= P.
  - prev2 <= prev1.
  - prev1 <= G.
  - v2 <= v1.
  - v1 <= 1.
- Classification at edge k, in priority order (first match wins):
  1. P == 0 -> ST_EXTINCT.
  2. v1 && G == prev1 -> ST_STILL.
  3. v2 && G == prev2 && G != prev1 -> ST_OSC2.
  4. k == MAX_GENS -> ST_TIMEOUT.
  5. Otherwise stay ST_RUN.
- On a match: status, done <= 1, done_pulse <= 1 and final_cells <= G all update at that same edge, so latency is 1 edge after the generation is presented.
- done_pulse clears on the next edge.
- FSM states:
  - RUN -> {EXTINCT, STILL, OSC2, TIMEOUT}.
  - Every terminal state is absorbing until rst.
- Freeze: while done=1, all outputs and prev registers hold regardless of cells.
- The counter never wraps, because MAX_GENS bounds it.
- Reset mid-run or after done: the next edge with rst=1 clears everything. The first edge after rst drops is again edge 1.
- Simultaneous conditions: an empty grid equal to prev1 reports EXTINCT, not STILL. A still life is never reported as OSC2 because of the G != prev1 guard.
- Edges 1 and 2 can only report EXTINCT/STILL (edge 1: EXTINCT only). OSC2 becomes possible from edge 3.

Decomposition:
- life_pkg:
  - GRID_N = 8.
  - CELLS_W = 64.
  - typedef enum logic [2:0] status_e: ST_RUN=0, ST_STILL=1, ST_OSC2=2, ST_EXTINCT=3, ST_TIMEOUT=4.
- Sub-module popcount64: purely combinational; input 64 bits, output 7-bit count.
- Everything else lives inline in life_monitor.

Test Plan:
- All-zero seeds, release rst -> after edge 1: status=ST_EXTINCT, done=1, gen_count=1, population=0, done_pulse high for exactly 1 cycle.
- 2x2 block at bits 27,28,35,36 -> edge 1: ST_RUN, population=4. Edge 2: ST_STILL, gen_count=2, final_cells=64'h0000_0018_1800_0000.
- Blinker at bits 26,27,28 -> edges 1-2: ST_RUN, population=3. Edge 3: ST_OSC2, gen_count=3, final_cells has bits 26,27,28 set.
- Single cell at bit 9 -> edge 1: population=1, ST_RUN. Edge 2: ST_EXTINCT, gen_count=2, population=0.
- MAX_GENS=4, glider at bits 1,10,16,17,18 -> edges 1-3: ST_RUN, population=5. Edge 4: ST_TIMEOUT, gen_count=4. Outputs then stay frozen for 10 further cycles while cells keep changing.
- Block run to done, then pulse rst for 1 cycle with blinker seeds -> the edge under rst clears all outputs. The run restarts and reaches ST_OSC2 at edge 3.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and sizes for the 8x8 Game-of-Life grid and its run monitor.
package life_pkg;

  localparam int GRID_N  = 8;
  localparam int CELLS_W = 64;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_STILL   = 3'd1,
    ST_OSC2    = 3'd2,
    ST_EXTINCT = 3'd3,
    ST_TIMEOUT = 3'd4
  } status_e;

endpackage

// File: rtl/popcount64.sv
// Live-cell counter over the flattened grid; purely combinational, zero latency.
module popcount64
  import life_pkg::*;
(
  input  logic [CELLS_W-1:0] vec,
  output logic [6:0]         count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < CELLS_W; i++) begin
      count = count + 7'(vec[i]);
    end
  end

endmodule

// File: rtl/life_monitor.sv
// Observes one generation per clock and classifies the run; result appears one edge after
// the deciding generation, then everything freezes until rst (no backpressure, never stalls).
module life_monitor
  import life_pkg::*;
#(
  parameter int MAX_GENS = 1000,
  parameter int GEN_W    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [GRID_N-1:0][GRID_N-1:0]  cells,
  output logic [GEN_W-1:0]               gen_count,
  output logic [6:0]                     population,
  output status_e                        status,
  output logic                           done,
  output logic                           done_pulse,
  output logic [CELLS_W-1:0]             final_cells
);

  logic [CELLS_W-1:0] grid;
  logic [CELLS_W-1:0] prev1;
  logic [CELLS_W-1:0] prev2;
  logic               v1;
  logic               v2;
  logic [6:0]         pop;
  logic [GEN_W-1:0]   gen_next;
  status_e            state_nxt;

  assign grid     = cells;
  assign gen_next = gen_count + GEN_W'(1);
  assign done     = (status != ST_RUN);

  popcount64 u_popcount (
    .vec   (grid),
    .count (pop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      status <= ST_RUN;
    end else begin
      status <= state_nxt;
    end
  end

  // Terminal states are absorbing; only RUN evaluates the priority chain.
  always_comb begin
    state_nxt = status;
    if (status == ST_RUN) begin
      if (pop == 7'd0) begin
        state_nxt = ST_EXTINCT;
      end else if (v1 && grid == prev1) begin
        state_nxt = ST_STILL;
      end else if (v2 && grid == prev2 && grid != prev1) begin
        state_nxt = ST_OSC2;
      end else if (gen_next == GEN_W'(MAX_GENS)) begin
        state_nxt = ST_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gen_count   <= '0;
      population  <= '0;
      prev1       <= '0;
      prev2       <= '0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      done_pulse  <= 1'b0;
      final_cells <= '0;
    end else begin
      done_pulse <= (status == ST_RUN) && (state_nxt != ST_RUN);
      if (!done) begin
        gen_count  <= gen_next;
        population <= pop;
        prev2      <= prev1;
        prev1      <= grid;
        v2         <= v1;
        v1         <= 1'b1;
        if (state_nxt != ST_RUN) begin
          final_cells <= grid;
        end
      end
    end
  end

endmodule
